// File: rtl/uart_tx_pkg.sv
// Shared UART transmit constants: FSM state encodings, default bit divider,
// serial line levels and bus read-request levels.
package uart_tx_pkg;

  localparam int UART_DIV_RATE = 434;  // 50 MHz / 115200

  localparam logic [2:0] UART_TX_IDLE      = 3'd0;
  localparam logic [2:0] UART_TX_LOAD      = 3'd1;
  localparam logic [2:0] UART_TX_START_BIT = 3'd2;
  localparam logic [2:0] UART_TX_DATA_BITS = 3'd3;
  localparam logic [2:0] UART_TX_STOP_BIT  = 3'd4;
  localparam logic [2:0] UART_TX_FINISH    = 3'd5;

  localparam logic UART_TX_IDLE_LVL  = 1'b1;
  localparam logic UART_TX_START_LVL = 1'b0;
  localparam logic UART_TX_STOP_LVL  = 1'b1;

  localparam logic READ_REQ_EN  = 1'b1;
  localparam logic READ_REQ_DIS = 1'b0;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period divider: load starts a DIV_RATE-cycle period, tick marks its final cycle.
// No backpressure; tick is a combinational decode of the counter.
module uart_baud_cnt
  import uart_tx_pkg::*;
#(
  parameter int DIV_RATE = UART_DIV_RATE
) (
  input  logic clk,
  input  logic resetn,
  input  logic load,
  output logic tick
);

  localparam int CW = $clog2(DIV_RATE);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(DIV_RATE - 1);
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/uart_tx.sv
// Fetches up to FIFO_WORDS bus words into a byte buffer, then sends each byte as an 8N1 frame.
// First start bit one cycle after the last capture; 10*DIV_RATE cycles per byte; bus stalls just hold LOAD.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int DIV_RATE   = UART_DIV_RATE,
  parameter int FIFO_WORDS = 4,
  parameter int WN_W       = 3
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start,
  input  logic [WN_W-1:0] word_number,
  output logic            uart_slave_read_req,
  input  logic            uart_slave_read_valid,
  input  logic [31:0]     uart_slave_read_data,
  output logic            tx,
  output logic            busy,
  output logic            done
);

  localparam int NBYTES = 4 * FIFO_WORDS;
  localparam int AW     = $clog2(NBYTES);
  localparam int BI_W   = AW + 1;  // one spare bit so the byte index never wraps

  logic [2:0]      state;
  logic [WN_W-1:0] limit;
  logic [WN_W-1:0] lim_in;
  logic [WN_W-1:0] word_cnt;
  logic [BI_W-1:0] byte_idx;
  logic [BI_W-1:0] last_byte;
  logic [2:0]      bit_idx;
  logic [7:0]      fifo [NBYTES];
  logic [AW-1:0]   wr_base;
  logic            tick;
  logic            baud_load;
  logic            in_bit;
  logic            capture;
  logic            last_word;

  // Oversized requests are clamped to the buffer depth rather than wrapped.
  assign lim_in    = (int'(word_number) > FIFO_WORDS) ? WN_W'(FIFO_WORDS) : word_number;
  assign capture   = (state == UART_TX_LOAD) && uart_slave_read_valid;
  assign last_word = (word_cnt == limit - WN_W'(1));
  assign last_byte = BI_W'({limit, 2'b00}) - BI_W'(1);
  assign wr_base   = AW'({word_cnt, 2'b00});
  assign in_bit    = (state == UART_TX_START_BIT) || (state == UART_TX_DATA_BITS) ||
                     (state == UART_TX_STOP_BIT);
  assign baud_load = (capture && last_word) || (in_bit && tick);

  uart_baud_cnt #(
    .DIV_RATE(DIV_RATE)
  ) u_baud (
    .clk   (clk),
    .resetn(resetn),
    .load  (baud_load),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (capture) begin
      for (int i = 0; i < 4; i++) begin
        fifo[wr_base + AW'(i)] <= uart_slave_read_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state    <= UART_TX_IDLE;
      limit    <= '0;
      word_cnt <= '0;
      byte_idx <= '0;
      bit_idx  <= '0;
    end else begin
      case (state)
        UART_TX_IDLE: begin
          if (start) begin
            limit    <= lim_in;
            word_cnt <= '0;
            byte_idx <= '0;
            bit_idx  <= '0;
            state    <= (lim_in == '0) ? UART_TX_FINISH : UART_TX_LOAD;
          end
        end
        UART_TX_LOAD: begin
          if (capture) begin
            word_cnt <= word_cnt + WN_W'(1);
            if (last_word) state <= UART_TX_START_BIT;
          end
        end
        UART_TX_START_BIT: begin
          if (tick) begin
            bit_idx <= '0;
            state   <= UART_TX_DATA_BITS;
          end
        end
        UART_TX_DATA_BITS: begin
          if (tick) begin
            if (bit_idx == 3'd7) state <= UART_TX_STOP_BIT;
            else bit_idx <= bit_idx + 3'd1;
          end
        end
        UART_TX_STOP_BIT: begin
          if (tick) begin
            byte_idx <= byte_idx + BI_W'(1);
            state    <= (byte_idx == last_byte) ? UART_TX_FINISH : UART_TX_START_BIT;
          end
        end
        UART_TX_FINISH: state <= UART_TX_IDLE;
        default:        state <= UART_TX_IDLE;
      endcase
    end
  end

  always_comb begin
    tx = UART_TX_IDLE_LVL;
    case (state)
      UART_TX_START_BIT: tx = UART_TX_START_LVL;
      UART_TX_DATA_BITS: tx = fifo[byte_idx[AW-1:0]][bit_idx];
      UART_TX_STOP_BIT:  tx = UART_TX_STOP_LVL;
      default:           tx = UART_TX_IDLE_LVL;
    endcase
  end

  assign busy                = (state != UART_TX_IDLE);
  assign done                = (state == UART_TX_FINISH);
  assign uart_slave_read_req = (state == UART_TX_LOAD) ? READ_REQ_EN : READ_REQ_DIS;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at DIV_RATE=4: stimulus queues expected bytes,
// a negedge line monitor decodes 8N1 frames and compares them in order.
module tb_uart_tx;

  localparam int DIV = 4;
  localparam int FW  = 4;
  localparam int WNW = 3;

  logic           clk = 1'b0;
  logic           resetn = 1'b1;
  logic           start = 1'b0;
  logic [WNW-1:0] word_number = '0;
  logic           req;
  logic           valid = 1'b0;
  logic [31:0]    data = '0;
  logic           tx;
  logic           busy;
  logic           done;

  uart_tx #(
    .DIV_RATE  (DIV),
    .FIFO_WORDS(FW),
    .WN_W      (WNW)
  ) dut (
    .clk                  (clk),
    .resetn               (resetn),
    .start                (start),
    .word_number          (word_number),
    .uart_slave_read_req  (req),
    .uart_slave_read_valid(valid),
    .uart_slave_read_data (data),
    .tx                   (tx),
    .busy                 (busy),
    .done                 (done)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_q[$];
  int         cyc = 0;
  int         done_cnt = 0;
  int         frame_cnt = 0;
  int         tx_toggles = 0;
  logic       tx_prev = 1'b1;
  logic       m_act = 1'b0;
  int         m_cnt = 0;
  logic [7:0] m_byte = '0;

  always @(posedge clk) cyc++;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  // Line monitor: start bit detected on first low sample, every bit sampled mid-period.
  always @(negedge clk) begin
    if (resetn) begin
      m_act   = 1'b0;
      tx_prev = tx;
    end else begin
      if (done === 1'b1) done_cnt++;
      if (tx !== tx_prev) tx_toggles++;
      tx_prev = tx;
      if (!m_act) begin
        if (tx === 1'b0) begin
          m_act = 1'b1;
          m_cnt = 0;
        end
      end else begin
        m_cnt++;
        if (m_cnt == DIV/2) begin
          chk("start_bit", {31'd0, tx}, 32'd0);
          if (tx !== 1'b0) m_act = 1'b0;
        end else if (m_cnt >= DIV + DIV/2 && m_cnt <= 8*DIV + DIV/2 && (m_cnt % DIV) == DIV/2) begin
          m_byte[m_cnt/DIV - 1] = tx;
        end else if (m_cnt == 9*DIV + DIV/2) begin
          chk("stop_bit", {31'd0, tx}, 32'd1);
          frame_cnt++;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_frame: got %0h, expected no frame", m_byte);
          end else begin
            chk("frame_byte", {24'd0, m_byte}, {24'd0, exp_q.pop_front()});
          end
          m_act = 1'b0;
        end
      end
    end
  end

  task automatic issue_start(input logic [WNW-1:0] wn);
    @(posedge clk); #1;
    start = 1'b1;
    word_number = wn;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feed(input logic [31:0] w);
    valid = 1'b1;
    data = w;
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
  endtask

  task automatic wait_tx_fall(output int c);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (tx !== 1'b0 && k < 2000);
    if (tx !== 1'b0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL tx_fall_timeout: got no start bit, expected one within 2000 cycles");
    end
    c = cyc;
  endtask

  task automatic wait_done(output int c);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (done !== 1'b1 && k < 2000);
    if (done !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: got no done, expected one within 2000 cycles");
    end
    c = cyc;
  endtask

  task automatic end_of_xfer(input string tag, input int frames);
    @(negedge clk);
    chk({tag, "_done_low"}, {31'd0, done}, 32'd0);
    chk({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_frames"}, frame_cnt, frames);
    chk({tag, "_queue_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    int c0, c1, caps;
    logic ok_req, ok_tx;

    // Reset and idle line
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_req", {31'd0, req}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    resetn = 1'b0;
    tx_toggles = 0;
    repeat (100) @(posedge clk);
    #1;
    chk("idle_toggles", tx_toggles, 0);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // Single word, valid on the first LOAD cycle
    done_cnt = 0; frame_cnt = 0;
    push_word(32'h44332211);
    issue_start(3'd1);
    valid = 1'b1;
    data = 32'h44332211;
    #3;
    chk("load_req", {31'd0, req}, 32'd1);
    chk("load_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    valid = 1'b0;
    chk("req_drop", {31'd0, req}, 32'd0);
    wait_tx_fall(c0);
    wait_done(c1);
    chk("done_latency", c1 - c0, 160);
    end_of_xfer("single", 4);

    // Stalled bus: captures on LOAD cycles 3 and 7 only
    done_cnt = 0; frame_cnt = 0;
    push_word(32'hA5A5A5A5);
    push_word(32'h0F0F0F0F);
    issue_start(3'd2);
    ok_req = 1'b1; ok_tx = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      if (i == 3) begin
        valid = 1'b1; data = 32'hA5A5A5A5;
      end else if (i == 7) begin
        valid = 1'b1; data = 32'h0F0F0F0F;
      end else begin
        valid = 1'b0; data = 32'hDEADBEEF;
      end
      #3;
      if (req !== 1'b1) ok_req = 1'b0;
      if (tx !== 1'b1) ok_tx = 1'b0;
      @(posedge clk); #1;
    end
    chk("stall_req_held", {31'd0, ok_req}, 32'd1);
    chk("stall_tx_idle", {31'd0, ok_tx}, 32'd1);
    chk("stall_req_drop", {31'd0, req}, 32'd0);
    feed(32'hFFFFFFFF);  // must be ignored: req already low
    wait_done(c1);
    end_of_xfer("stall", 8);

    // Zero words: straight to FINISH, line untouched
    done_cnt = 0; frame_cnt = 0; tx_toggles = 0;
    issue_start(3'd0);
    #3;
    chk("zero_done", {31'd0, done}, 32'd1);
    chk("zero_req", {31'd0, req}, 32'd0);
    @(posedge clk); #4;
    chk("zero_done_low", {31'd0, done}, 32'd0);
    chk("zero_busy_low", {31'd0, busy}, 32'd0);
    repeat (20) @(posedge clk);
    #1;
    chk("zero_toggles", tx_toggles, 0);
    chk("zero_done_pulses", done_cnt, 1);

    // Clamp: word_number=7 takes only FIFO_WORDS words
    done_cnt = 0; frame_cnt = 0;
    for (int b = 0; b < 16; b++) exp_q.push_back(8'(b));
    issue_start(3'd7);
    caps = 0;
    for (int i = 0; i < 8; i++) begin
      valid = 1'b1;
      data = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
      #3;
      if (req === 1'b1) caps++;
      @(posedge clk); #1;
    end
    valid = 1'b0;
    chk("clamp_words", caps, 4);
    wait_done(c1);
    end_of_xfer("clamp", 16);

    // Reset during bit 3 of the second byte
    done_cnt = 0; frame_cnt = 0;
    push_word(32'h44332211);
    issue_start(3'd1);
    feed(32'h44332211);
    wait_tx_fall(c0);
    repeat (57) @(negedge clk);
    #1;
    chk("mid_tx_low_before_rst", {31'd0, tx}, 32'd0);
    resetn = 1'b1;
    #1;
    chk("async_rst_tx", {31'd0, tx}, 32'd1);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b0;
    done_cnt = 0; frame_cnt = 0;
    push_word(32'h000000FF);
    issue_start(3'd1);
    feed(32'h000000FF);
    wait_done(c1);
    end_of_xfer("post_rst", 4);

    // Start pulse during DATA_BITS is ignored
    done_cnt = 0; frame_cnt = 0;
    push_word(32'h78563412);
    issue_start(3'd1);
    feed(32'h78563412);
    wait_tx_fall(c0);
    repeat (10) @(negedge clk);
    @(posedge clk); #1;
    start = 1'b1;
    word_number = 3'd3;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(c1);
    chk("busy_start_latency", c1 - c0, 160);
    repeat (60) @(negedge clk);
    chk("busy_start_done_pulses", done_cnt, 1);
    chk("busy_start_frames", frame_cnt, 4);
    chk("busy_start_queue", exp_q.size(), 0);
    chk("busy_start_idle", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
Transmit-side UART stage, the counterpart to the UART receive path. On a start command it fetches N 32-bit words over the bus-slave read handshake into a byte FIFO. It then serialises every byte onto the tx line as 8N1 frames at a fixed divided bit rate. Byte and bit ordering match the receiver: byte 0 of each word (data[7:0]) goes first, and each byte is sent LSB first.

Parameters:
DIV_RATE, 434, clk cycles per serial bit (50 MHz / 115200); must be >= 2
FIFO_WORDS, 4, word capacity of the byte FIFO (4*FIFO_WORDS bytes, 16 by default)
WN_W, 3, width of word_number

Ports:
clk  input  1  system clock; all state changes on rising edge
resetn  input  1  reset, asynchronous, active-high (the port keeps the codebase name; asserted = 1)
start  input  1  one-cycle command pulse; sampled only in IDLE
word_number  input  WN_W  words to send, sampled with start
uart_slave_read_req  output  1  high while words are still owed to the FIFO
uart_slave_read_valid  input  1  read data valid; one word captured per cycle while req=1
uart_slave_read_data  input  32  word from bus
tx  output  1  serial line, idle high
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when the last stop bit completes

Behaviour:
- Reset values (asynchronous, immediate, including mid-frame): tx=1, busy=0, done=0, uart_slave_read_req=0. State is IDLE. Byte count, word count, bit count and divider counter are 0. FIFO contents are don't-care.
- States: IDLE, LOAD, START_BIT, DATA_BITS, STOP_BIT, FINISH.
- IDLE: tx=1. When start=1, latch limit = min(word_number, FIFO_WORDS).
  - limit=0: go to FINISH.
  - Otherwise go to LOAD and clear the counters.
  - start is ignored in every other state.
- LOAD: uart_slave_read_req=1 from the first LOAD cycle.
  - On each cycle with valid=1, write data[7:0], [15:8], [23:16], [31:24] to FIFO bytes 4k..4k+3, then k++.
  - On the cycle that captures word limit-1, req drops (registered: req=0 from the next cycle) and the state goes to START_BIT.
  - valid while req=0 is ignored.
- Bit timing: the divider loads DIV_RATE-1 on entry to each bit, counts down every cycle, and the bit ends on the cycle the count is 0. Every bit is therefore exactly DIV_RATE cycles.
- START_BIT: tx=0 for one bit time, then DATA_BITS with bit index 0.
- DATA_BITS: tx = fifo[byte_idx][bit_idx]. After bit 7 go to STOP_BIT.
- STOP_BIT: tx=1 for one bit time. Then byte_idx++.
  - If byte_idx == 4*limit-1 before the increment: go to FINISH.
  - Otherwise go to START_BIT. Frames are back-to-back, with no extra idle.
- FINISH: done=1 for exactly this one cycle, tx=1, then IDLE. busy falls together with the return to IDLE.
- Frame length: 10*DIV_RATE cycles per byte. The first tx falling edge appears one cycle after the final word capture.
- Width rules:
  - Byte index width is clog2(4*FIFO_WORDS)+1, so no wrap is possible.
  - word_number values above FIFO_WORDS are clamped, never wrapped. For example, word_number=7 sends 16 bytes.
- Simultaneous events: start and reset asserted together → reset wins. valid asserted in the same cycle LOAD is entered → captured.

Decomposition:
- Shared uart header/package holds:
  - state encodings (UART_TX_* names, distinct from the receiver's);
  - DIV_RATE default;
  - TX idle/start/stop bit levels;
  - READ_REQ enable/disable levels.
- One natural sub-module, uart_baud_cnt: divider counter with load and a tick output. It is reusable by the receiver.
- FIFO storage and the FSM stay in uart_tx.

Test Plan:
- All tests use DIV_RATE=4.
- Reset idle: hold resetn=1 for 3 cycles then release → tx=1, busy=0, req=0, done=0; no tx toggles for 100 cycles.
- Single word: start with word_number=1, valid on the first LOAD cycle with data 32'h44332211 → frames 0x11, 0x22, 0x33, 0x44 in that order. Each frame is 40 cycles (start 0, LSB first, stop 1). done pulses once, 160 cycles after the first tx fall.
- Stalled bus: word_number=2, valid asserted only on cycles 3 and 7 of LOAD (data 32'hA5A5A5A5, 32'h0F0F0F0F) → req stays high until the second capture, tx stays 1 meanwhile, and 8 bytes are sent in correct order.
- Zero and clamp: word_number=0 → done pulse 2 cycles after start, tx never leaves 1. word_number=7 → exactly 4 words requested and 16 frames sent.
- Reset mid-frame: assert resetn during bit 3 of the second byte → tx=1 immediately and asynchronously, busy=0. A following start with word_number=1 and data 32'h000000FF transmits cleanly.
- Start while busy: pulse start during DATA_BITS with a different word_number → ignored; byte count is unchanged and done pulses once.
